mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM-stage engine of the RISC-V core, driven directly by the EX/MEM pipeline register outputs.
- Executes loads and stores over a byte-wide synchronous RAM port, one byte per cycle, and requests a pipeline stall until the access completes.
- Passes non-memory results through unchanged.
- Its outputs feed the MEM/WB register.

Parameters:
- ADDR_W, 32, width of the effective address and of ram_addr.
- OP_LOAD, 7'b0000011, aluop value identifying loads.
- OP_STORE, 7'b0100011, aluop value identifying stores.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- mem_aluop  in  7  opcode from EX/MEM.
- mem_alufunct3  in  3  width/sign selector.
- mem_me  in  1  memory-op enable from EX/MEM; an access starts only if mem_me=1 and aluop is LOAD/STORE.
- mem_maddr  in  ADDR_W  effective address.
- mem_wreg  in  1  register write enable.
- mem_wd  in  5  destination register.
- mem_wdata  in  32  ALU result; for stores, the rs2 store data.
- wb_wreg  out  1  to MEM/WB.
- wb_wd  out  5  to MEM/WB.
- wb_wdata  out  32  to MEM/WB.
- stall_req  out  1  to pipeline control; while 1, PC/IF/ID/EX/MEM registers hold.
- ram_addr  out  ADDR_W  byte address.
- ram_wr  out  1  1 = write ram_dout this cycle.
- ram_dout  out  8  write byte.
- ram_din  in  8  read byte; valid the cycle after its address is presented.
- misalign  out  1  optional, see below.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, cnt=0, load buffer=0.
  - All outputs 0: stall_req, ram_wr, ram_addr, ram_dout, wb_*.
  - Reset mid-access aborts it immediately, with no further RAM writes.
- Size N from funct3:
  - 000 → 1 byte (LB/SB), 001 → 2 (LH/SH), 010 → 4 (LW/SW), 100 → 1 (LBU), 101 → 2 (LHU).
  - Other funct3 values with LOAD/STORE are a no-op: no RAM access, wb_wreg=0, no stall.
  - 100 and 101 with STORE are also a no-op.
- States: IDLE, BUSY, TAIL, DONE.
- IDLE:
  - Non-memory op: wb_* = mem_* combinationally; stall_req=0; ram_wr=0.
  - Valid memory op: stall_req=1, cnt←0, next state BUSY.
- BUSY:
  - stall_req=1; ram_addr = mem_maddr+cnt, mod 2^ADDR_W, wraps at the top of the address space.
  - Store: ram_wr=1, ram_dout = mem_wdata[8*cnt+7:8*cnt] (little-endian).
  - Load: ram_wr=0; when cnt>0, capture ram_din into buffer byte cnt-1.
  - cnt increments each cycle. When cnt=N-1, next state is TAIL for a load or DONE for a store.
- TAIL (loads only):
  - stall_req=1, ram_wr=0; capture ram_din into buffer byte N-1; next state DONE.
- DONE:
  - stall_req=0, ram_wr=0, wb_wd=mem_wd.
  - Load: wb_wreg=mem_wreg, and wb_wdata is the buffer result.
  - Load extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
  - Store: wb_wreg=0, wb_wdata=0.
  - Next state IDLE; the pipeline advances on this edge.
- Stall cycles, i.e. cycles with stall_req=1:
  - Store: N+1.
  - Load: N+2.
  - Examples: SB 2, SW 5, LB 3, LW 6.
- While stall_req=1:
  - mem_* inputs are held stable by pipeline control.
  - wb_wreg=0, so MEM/WB captures a bubble.
- Back-to-back memory ops: DONE→IDLE takes one edge, and the new op's IDLE cycle starts immediately with no extra gap cycle.
- Alignment: byte-serial accesses accept any alignment when the optional feature is absent.
- wd=0 is passed through; the register file ignores it.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - Halfword ops with maddr[0]≠0, and word ops with maddr[1:0]≠0, perform no RAM access and no stall.
  - They pulse misalign=1 for exactly one cycle; wb_wreg=0.
- Undefined:
  - misalign is tied 0 and misaligned accesses proceed byte-serially.

Test Plan:
- Reset asserted mid-SW (after 2 bytes written) → ram_wr=0 immediately, state IDLE; after release, no further writes; the next ADD passes through.
- SW, maddr=0x100, data=0xA1B2C3D4 → writes 0xD4@0x100, 0xC3@0x101, 0xB2@0x102, 0xA1@0x103 on consecutive cycles; stall_req high for 5 cycles; wb_wreg=0.
- RAM 0x200..0x203 = 0x80,0xFF,0x12,0x34; LW x5 @0x200 → stall 6 cycles, then wb_wd=5, wb_wdata=0x3412FF80, wb_wreg=1.
- Same RAM: LB @0x200 → 0xFFFFFF80; LBU → 0x00000080; LH → 0xFFFFFF80; LHU → 0x0000FF80.
- ADD result 0x1234 to x3 with mem_me=0 → wb same cycle, stall_req never 1, ram_wr never 1.
- LH @0xFFFFFFFF → bytes read from 0xFFFFFFFF then 0x00000000 (wrap). With MEM_ALIGN_CHECK_EN: no access, misalign pulses 1 cycle, wb_wreg=0.

Source files
------------

// File: rtl/mem_access.sv
// MEM-stage byte-serial load/store engine over a synchronous byte RAM port.
// Define MEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module mem_access #(
  parameter int          ADDR_W   = 32,
  parameter logic [6:0]  OP_LOAD  = 7'b0000011,
  parameter logic [6:0]  OP_STORE = 7'b0100011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        mem_aluop,
  input  logic [2:0]        mem_alufunct3,
  input  logic              mem_me,
  input  logic [ADDR_W-1:0] mem_maddr,
  input  logic              mem_wreg,
  input  logic [4:0]        mem_wd,
  input  logic [31:0]       mem_wdata,
  output logic              wb_wreg,
  output logic [4:0]        wb_wd,
  output logic [31:0]       wb_wdata,
  output logic              stall_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, TAIL, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic [1:0]  cnt_m1;
  logic [1:0]  last_cnt;
  logic [31:0] ld_buf;
  logic [31:0] ld_ext;
  logic [2:0]  nbytes;
  logic        is_load, is_store, misaligned, start;

  always_comb begin
    is_load  = mem_me && (mem_aluop == OP_LOAD);
    is_store = mem_me && (mem_aluop == OP_STORE);
    nbytes   = '0;
    case (mem_alufunct3)
      3'b000:  nbytes = 3'd1;
      3'b001:  nbytes = 3'd2;
      3'b010:  nbytes = 3'd4;
      3'b100:  nbytes = is_load ? 3'd1 : 3'd0;
      3'b101:  nbytes = is_load ? 3'd2 : 3'd0;
      default: nbytes = '0;
    endcase
    last_cnt = 2'(nbytes - 3'd1);
    cnt_m1   = cnt - 2'd1;
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = ((nbytes == 3'd2) && mem_maddr[0]) ||
                 ((nbytes == 3'd4) && (mem_maddr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    start = (is_load || is_store) && (nbytes != 3'd0) && !misaligned;
  end

  always_comb begin
    case (mem_alufunct3)
      3'b000:  ld_ext = {{24{ld_buf[7]}}, ld_buf[7:0]};
      3'b001:  ld_ext = {{16{ld_buf[15]}}, ld_buf[15:0]};
      3'b100:  ld_ext = {24'b0, ld_buf[7:0]};
      3'b101:  ld_ext = {16'b0, ld_buf[15:0]};
      default: ld_ext = ld_buf;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ld_buf <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          cnt    <= '0;
          ld_buf <= '0;
        end
        // RAM data lags its address by one cycle, so byte cnt-1 arrives now
        BUSY: begin
          cnt <= cnt + 2'd1;
          if (is_load && (cnt != 2'd0))
            ld_buf[{cnt_m1, 3'b000} +: 8] <= ram_din;
        end
        TAIL: ld_buf[{last_cnt, 3'b000} +: 8] <= ram_din;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    stall_req = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = '0;
    ram_dout  = '0;
    wb_wreg   = 1'b0;
    wb_wd     = '0;
    wb_wdata  = '0;
    misalign  = 1'b0;
    case (state)
      IDLE: begin
        if (is_load || is_store) begin
          wb_wd = mem_wd;
          if (start) begin
            stall_req = 1'b1;
            state_nxt = BUSY;
          end else begin
            misalign = misaligned;
          end
        end else begin
          wb_wreg  = mem_wreg;
          wb_wd    = mem_wd;
          wb_wdata = mem_wdata;
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        ram_addr  = mem_maddr + ADDR_W'(cnt);
        if (is_store) begin
          ram_wr   = 1'b1;
          ram_dout = mem_wdata[{cnt, 3'b000} +: 8];
        end
        if (cnt == last_cnt)
          state_nxt = is_load ? TAIL : DONE;
      end
      TAIL: begin
        stall_req = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        wb_wd = mem_wd;
        if (is_load) begin
          wb_wreg  = mem_wreg;
          wb_wdata = ld_ext;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // outputs read zero for the whole time reset is held, not just from the next edge
    if (!rst) begin
      stall_req = 1'b0;
      ram_wr    = 1'b0;
      ram_addr  = '0;
      ram_dout  = '0;
      wb_wreg   = 1'b0;
      wb_wd     = '0;
      wb_wdata  = '0;
      misalign  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected writes/writebacks/stall
// lengths into queues; a negedge monitor pops and compares as the DUT produces them.
module tb_mem_access;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] ALU = 7'b0110011;

  typedef struct packed { logic [31:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic [4:0] wd; logic [31:0] wdata; } wb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  mem_aluop = '0;
  logic [2:0]  mem_alufunct3 = '0;
  logic        mem_me = 1'b0;
  logic [31:0] mem_maddr = '0;
  logic        mem_wreg = 1'b0;
  logic [4:0]  mem_wd = '0;
  logic [31:0] mem_wdata = '0;
  logic        wb_wreg, stall_req, ram_wr, misalign;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata, ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;

  wr_t wr_q[$];
  wb_t wb_q[$];
  int  stall_q[$];
  int  mis_q[$];

  int  checks = 0;
  int  errors = 0;
  int  run_len = 0;
  logic finish_req = 1'b0;
  logic final_done = 1'b0;

  logic [7:0] ram [logic [31:0]];

  mem_access #(.ADDR_W(32), .OP_LOAD(LD), .OP_STORE(ST)) dut (
    .clk(clk), .rst(rst),
    .mem_aluop(mem_aluop), .mem_alufunct3(mem_alufunct3), .mem_me(mem_me),
    .mem_maddr(mem_maddr), .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata), .stall_req(stall_req),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  // synchronous byte RAM: read data appears the cycle after the address
  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr] = ram_dout;
    ram_din <= ram.exists(ram_addr) ? ram[ram_addr] : 8'h00;
  end

  always @(negedge clk) begin
    if (!rst) begin
      run_len = 0;
      checks++;
      if ({stall_req, ram_wr, ram_addr, ram_dout, wb_wreg, wb_wd, wb_wdata, misalign} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got stall=%b wr=%b addr=%h dout=%h wreg=%b wd=%0d wdata=%h mis=%b exp all zero",
                 stall_req, ram_wr, ram_addr, ram_dout, wb_wreg, wb_wd, wb_wdata, misalign);
      end
    end else begin
      if (stall_req) run_len++;
      else if (run_len != 0) begin
        checks++;
        if (stall_q.size() == 0) begin
          errors++;
          $display("FAIL stall_len got %0d cycles exp none", run_len);
        end else begin
          int e;
          e = stall_q.pop_front();
          if (run_len != e) begin
            errors++;
            $display("FAIL stall_len got %0d exp %0d", run_len, e);
          end
        end
        run_len = 0;
      end
      if (ram_wr !== 1'b0) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL ram_write got %h@%h exp no write", ram_dout, ram_addr);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if (ram_wr !== 1'b1 || ram_addr !== w.addr || ram_dout !== w.data) begin
            errors++;
            $display("FAIL ram_write got %h@%h exp %h@%h", ram_dout, ram_addr, w.data, w.addr);
          end
        end
      end
      if (wb_wreg !== 1'b0) begin
        checks++;
        if (wb_q.size() == 0) begin
          errors++;
          $display("FAIL writeback got x%0d=%h exp no writeback", wb_wd, wb_wdata);
        end else begin
          wb_t b;
          b = wb_q.pop_front();
          if (wb_wreg !== 1'b1 || wb_wd !== b.wd || wb_wdata !== b.wdata) begin
            errors++;
            $display("FAIL writeback got x%0d=%h exp x%0d=%h", wb_wd, wb_wdata, b.wd, b.wdata);
          end
        end
      end
      if (misalign !== 1'b0) begin
        checks++;
        if (mis_q.size() == 0) begin
          errors++;
          $display("FAIL misalign got %b exp 0", misalign);
        end else begin
          void'(mis_q.pop_front());
        end
      end
    end
    if (finish_req && !final_done) begin
      checks += 4;
      if (wr_q.size() != 0) begin errors++; $display("FAIL pending_writes got %0d left exp 0", wr_q.size()); end
      if (wb_q.size() != 0) begin errors++; $display("FAIL pending_wb got %0d left exp 0", wb_q.size()); end
      if (stall_q.size() != 0) begin errors++; $display("FAIL pending_stalls got %0d left exp 0", stall_q.size()); end
      if (mis_q.size() != 0) begin errors++; $display("FAIL pending_misalign got %0d left exp 0", mis_q.size()); end
      final_done = 1'b1;
    end
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic me,
                       input logic [31:0] addr, input logic wreg, input logic [4:0] wd,
                       input logic [31:0] wdata);
    mem_aluop = op; mem_alufunct3 = f3; mem_me = me; mem_maddr = addr;
    mem_wreg = wreg; mem_wd = wd; mem_wdata = wdata;
  endtask

  // hold the op until the pipeline would advance (stall_req low before an edge)
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic me,
                       input logic [31:0] addr, input logic wreg, input logic [4:0] wd,
                       input logic [31:0] wdata);
    int n;
    drive(op, f3, me, addr, wreg, wd, wdata);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall_req && n < 50);
    if (stall_req) begin
      $display("FAIL stall_timeout got stall_req=1 after %0d cycles exp release", n);
      $fatal(1, "stall never released");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data, input int nb);
    for (int i = 0; i < nb; i++) begin
      logic [31:0] d;
      d = data >> (8 * i);
      wr_q.push_back('{addr: addr + 32'(i), data: d[7:0]});
    end
    stall_q.push_back(nb + 1);
    issue(ST, f3, 1'b1, addr, 1'b1, 5'd0, data);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] wd,
                      input logic [31:0] expv, input int nb);
    wb_q.push_back('{wd: wd, wdata: expv});
    stall_q.push_back(nb + 2);
    issue(LD, f3, 1'b1, addr, 1'b1, wd, 32'h0);
  endtask

  initial begin
    drive(ALU, 3'b000, 1'b0, 32'h0, 1'b1, 5'd3, 32'h1234);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // SW aborted by reset after two bytes
    wr_q.push_back('{addr: 32'h100, data: 8'h88});
    wr_q.push_back('{addr: 32'h101, data: 8'h77});
    drive(ST, 3'b010, 1'b1, 32'h100, 1'b0, 5'd0, 32'h55667788);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    drive(ALU, 3'b000, 1'b0, 32'h0, 1'b1, 5'd3, 32'h1234);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wb_q.push_back('{wd: 5'd3, wdata: 32'h1234});
    issue(ALU, 3'b000, 1'b0, 32'h0, 1'b1, 5'd3, 32'h1234);

    store(3'b010, 32'h100, 32'hA1B2C3D4, 4);
    store(3'b010, 32'h200, 32'h3412FF80, 4);
    load(3'b010, 32'h200, 5'd5, 32'h3412FF80, 4);
    load(3'b000, 32'h200, 5'd6, 32'hFFFFFF80, 1);
    load(3'b100, 32'h200, 5'd7, 32'h00000080, 1);
    load(3'b001, 32'h200, 5'd8, 32'hFFFFFF80, 2);
    load(3'b101, 32'h200, 5'd9, 32'h0000FF80, 2);
    store(3'b000, 32'hFFFFFFFF, 32'hAAAAAA11, 1);
    store(3'b000, 32'h0, 32'hBBBBBB92, 1);
    store(3'b001, 32'h300, 32'h1234BEEF, 2);
    load(3'b101, 32'h300, 5'd13, 32'h0000BEEF, 2);
`ifdef MEM_ALIGN_CHECK_EN
    mis_q.push_back(1);
    issue(LD, 3'b001, 1'b1, 32'hFFFFFFFF, 1'b1, 5'd10, 32'h0);
`else
    load(3'b001, 32'hFFFFFFFF, 5'd10, 32'hFFFF9211, 2);
`endif
    issue(LD, 3'b011, 1'b1, 32'h200, 1'b1, 5'd11, 32'h0);
    issue(ST, 3'b100, 1'b1, 32'h400, 1'b1, 5'd0, 32'hCAFEF00D);
    wb_q.push_back('{wd: 5'd12, wdata: 32'hDEAD});
    issue(LD, 3'b010, 1'b0, 32'h200, 1'b1, 5'd12, 32'hDEAD);
    wb_q.push_back('{wd: 5'd0, wdata: 32'h5});
    issue(ALU, 3'b000, 1'b0, 32'h0, 1'b1, 5'd0, 32'h5);
    drive(ALU, 3'b000, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);

    repeat (3) @(posedge clk);
    finish_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    if (!final_done) $display("FAIL final_check got not-run exp run");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
